// File: rtl/othello_pkg.sv
// -----------------------------------------------------------------------------
// othello_pkg
// Shared definitions for the board cell plotter: cell-state (select) encodings,
// tile colours, FSM state encoding, the buffered request layout and the
// per-pixel colour rule used when a tile is drawn.
// -----------------------------------------------------------------------------
package othello_pkg;

    // Cell state carried on the select lines
    localparam logic [1:0] SEL_EMPTY0 = 2'd0;
    localparam logic [1:0] SEL_EMPTY1 = 2'd1;
    localparam logic [1:0] SEL_WHITE  = 2'd2;
    localparam logic [1:0] SEL_BLACK  = 2'd3;

    // Tile colours
    localparam logic [2:0] COL_GRID  = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_BOARD = 3'b010;

    // Plotter FSM states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DRAW = 2'd2;

    // One buffered cell request, 17 bits: {x, y, select}
    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [1:0] sel;
    } cell_req_t;

    // Colour of pixel (i, j) inside a c x c tile. The last row and column form
    // the grid line; a disk occupies [2, c-3] in both axes with its four
    // corner pixels clipped so it reads as round.
    function automatic logic [2:0] cell_colour(input int i, input int j,
                                               input logic [1:0] sel, input int c,
                                               input logic [2:0] bg);
        logic in_i;
        logic in_j;
        logic corner;
        logic disk;
        in_i   = (i >= 2) && (i <= c - 3);
        in_j   = (j >= 2) && (j <= c - 3);
        corner = ((i == 2) || (i == c - 3)) && ((j == 2) || (j == c - 3));
        disk   = (sel == SEL_WHITE) || (sel == SEL_BLACK);
        if ((i == c - 1) || (j == c - 1))
            cell_colour = COL_GRID;
        else if (disk && in_i && in_j && !corner)
            cell_colour = (sel == SEL_WHITE) ? COL_WHITE : COL_BLACK;
        else
            cell_colour = bg;
    endfunction

endpackage

// File: rtl/cell_plotter_if.sv
// -----------------------------------------------------------------------------
// cell_plotter_if
// Cell plot request stream from the board RAM plot port.
//   x_plot [7:0]  tile top-left x pixel
//   y_plot [6:0]  tile top-left y pixel
//   select [1:0]  cell state (0/1 empty, 2 white disk, 3 black disk)
//   enable        request strobe
// Handshake: enable acts as a valid with no ready. Every clock on which enable
// is high carries exactly one request; the consumer cannot stall the producer,
// so a request arriving when the consumer has no room is dropped and flagged.
// -----------------------------------------------------------------------------
interface cell_plotter_if;
    logic [7:0] x_plot;
    logic [6:0] y_plot;
    logic [1:0] select;
    logic       enable;

    modport master (output x_plot, output y_plot, output select, output enable);
    modport slave  (input  x_plot, input  y_plot, input  select, input  enable);
endinterface

// File: rtl/plot_fifo.sv
// -----------------------------------------------------------------------------
// plot_fifo
// Synchronous FIFO for cell requests.
//   clock, resetn   clock and synchronous active-high reset
//   push, din       write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   full, empty     occupancy flags
//   dout            head entry, valid while not empty
// A push and a pop on the same edge is legal when full: the pop frees the
// slot the push fills.
// -----------------------------------------------------------------------------
module plot_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only read while the FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/cell_plotter.sv
// -----------------------------------------------------------------------------
// cell_plotter
// Renders each buffered board-cell request as a CELL_SIZE x CELL_SIZE tile of
// pixels for the VGA adapter, one pixel per clock.
//   clock, resetn   clock and synchronous active-high reset
//   req             cell request stream (slave side)
//   vga_x, vga_y    pixel address, registered, held when plot=0
//   colour          pixel colour, registered, held when plot=0
//   plot            pixel write strobe
//   busy            FIFO non-empty or FSM not idle
//   overflow        sticky: a request arrived with the FIFO full and was lost
//   dbg_state       current FSM state (IDLE/LOAD/DRAW)
// -----------------------------------------------------------------------------
module cell_plotter
    import othello_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         CELL_SIZE  = 12,
    parameter logic [2:0] BG_COLOUR  = COL_BOARD
) (
    input  logic           clock,
    input  logic           resetn,
    cell_plotter_if.slave  req,
    output logic [7:0]     vga_x,
    output logic [6:0]     vga_y,
    output logic [2:0]     colour,
    output logic           plot,
    output logic           busy,
    output logic           overflow,
    output logic [1:0]     dbg_state
);
    localparam int CW = $clog2(CELL_SIZE);
    localparam logic [CW-1:0] LAST = CW'(CELL_SIZE - 1);

    logic [1:0]    r_state;
    logic [7:0]    r_base_x;
    logic [6:0]    r_base_y;
    logic [1:0]    r_sel;
    logic [CW-1:0] r_i;
    logic [CW-1:0] r_j;
    logic [7:0]    r_vga_x;
    logic [6:0]    r_vga_y;
    logic [2:0]    r_colour;
    logic          r_plot;
    logic          r_overflow;

    cell_req_t     w_push_data;
    cell_req_t     w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_pop_eff;
    logic          w_push_ok;
    logic [2:0]    w_colour;

    assign w_push_data = {req.x_plot, req.y_plot, req.select};
    assign w_pop       = (r_state == LOAD);
    assign w_pop_eff   = w_pop && !w_empty;
    assign w_push_ok   = req.enable && (!w_full || w_pop_eff);
    assign w_colour    = cell_colour(int'(r_i), int'(r_j), r_sel, CELL_SIZE, BG_COLOUR);

    plot_fifo #(
        .WIDTH ($bits(cell_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (req.enable),
        .pop    (w_pop),
        .din    (w_push_data),
        .full   (w_full),
        .empty  (w_empty),
        .dout   (w_head)
    );

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state    <= IDLE;
            r_base_x   <= '0;
            r_base_y   <= '0;
            r_sel      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_vga_x    <= '0;
            r_vga_y    <= '0;
            r_colour   <= '0;
            r_plot     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            if (req.enable && !w_push_ok) r_overflow <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (!w_empty) r_state <= LOAD;
                end
                LOAD: begin
                    r_base_x <= w_head.x;
                    r_base_y <= w_head.y;
                    r_sel    <= w_head.sel;
                    r_i      <= '0;
                    r_j      <= '0;
                    r_state  <= DRAW;
                end
                DRAW: begin
                    // Address wraps silently modulo the screen size.
                    r_vga_x  <= r_base_x + 8'(r_i);
                    r_vga_y  <= r_base_y + 7'(r_j);
                    r_colour <= w_colour;
                    r_plot   <= 1'b1;
                    if (r_i == LAST) begin
                        r_i <= '0;
                        if (r_j == LAST) begin
                            r_j <= '0;
                            // A request pushed on this same edge counts as queued.
                            r_state <= (!w_empty || w_push_ok) ? LOAD : IDLE;
                        end else begin
                            r_j <= r_j + CW'(1);
                        end
                    end else begin
                        r_i <= r_i + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vga_x     = r_vga_x;
    assign vga_y     = r_vga_y;
    assign colour    = r_colour;
    assign plot      = r_plot;
    assign overflow  = r_overflow;
    assign busy      = !w_empty || (r_state != IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cell_plotter.sv
// -----------------------------------------------------------------------------
// tb_cell_plotter
// Self-checking bench for cell_plotter. Every accepted request is expanded by
// a reference model into the expected list of {x, y, colour} pixels in draw
// order; a monitor compares each plotted pixel against the head of that queue
// and also checks that every uninterrupted plot run is one full tile long.
// -----------------------------------------------------------------------------
module tb_cell_plotter;
    import othello_pkg::*;

    localparam int         C  = 12;
    localparam logic [2:0] BG = 3'b010;

    // ---------------- clock / reset ----------------
    logic clock  = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       overflow;
    logic [1:0] dbg_state;

    cell_plotter_if req_if();

    cell_plotter #(
        .FIFO_DEPTH (4),
        .CELL_SIZE  (C),
        .BG_COLOUR  (BG)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req_if),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [17:0] exp_q[$];
    int          n_plot = 0;
    int          run = 0;
    bit          skip_run = 1'b0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          last_cyc = 0;
    logic [2:0]  scr [256][128];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a tile is C rows of C pixels, x advancing fastest.
    task automatic add_tile(input logic [7:0] x, input logic [6:0] y, input logic [1:0] s);
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] col;
        for (int j = 0; j < C; j++) begin
            for (int i = 0; i < C; i++) begin
                px = 8'((int'(x) + i) % 256);
                py = 7'((int'(y) + j) % 128);
                if (i == C - 1 || j == C - 1)
                    col = 3'b000;
                else if (s >= 2'd2 && i >= 2 && i <= C - 3 && j >= 2 && j <= C - 3 &&
                         !((i == 2 || i == C - 3) && (j == 2 || j == C - 3)))
                    col = (s == 2'd2) ? 3'b111 : 3'b000;
                else
                    col = BG;
                exp_q.push_back({px, py, col});
            end
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clock) begin
        if (plot === 1'b1) begin
            n_plot++;
            run++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            scr[vga_x][vga_y] = colour;
            if (exp_q.size() == 0)
                chk("plot_with_nothing_expected", plot, 1'b0);
            else
                chk("pixel", {vga_x, vga_y, colour}, exp_q.pop_front());
        end else begin
            if (run != 0 && !skip_run) chk("run_len", run, C * C);
            run = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] x, input logic [6:0] y, input logic [1:0] s,
                          input bit accepted);
        req_if.x_plot = x;
        req_if.y_plot = y;
        req_if.select = s;
        req_if.enable = 1'b1;
        if (accepted) add_tile(x, y, s);
        tick(1);
        req_if.enable = 1'b0;
    endtask

    task automatic strobe_rand(input bit accepted);
        strobe(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)),
               2'($urandom_range(0, 3)), accepted);
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < maxc) begin
            tick(1);
            k++;
        end
        chk("idle_timeout", 32'(k >= maxc), 0);
        tick(3);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        tick(2);
        resetn = 1'b0;
        tick(1);
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        int k;

        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 128; b++)
                scr[a][b] = 3'b101;

        req_if.x_plot = '0;
        req_if.y_plot = '0;
        req_if.select = '0;
        req_if.enable = 1'b0;

        // Reset state
        tick(3);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        resetn = 1'b0;
        tick(2);

        // Single black tile at (9,9): first plot three cycles after the strobe edge
        strobe(8'd9, 7'd9, 2'd3, 1'b1);
        for (int d = 0; d < 3; d++) begin
            @(negedge clock);
            chk("latency_plot_low", plot, 0);
            chk("latency_busy", busy, 1);
            @(posedge clock);
        end
        @(negedge clock);
        chk("latency_first_plot", plot, 1);
        @(posedge clock);
        #1;
        wait_idle(400);
        chk("t1_pix_9_9", scr[9][9], 3'b010);
        chk("t1_pix_14_14", scr[14][14], 3'b000);
        chk("t1_pix_11_11_corner", scr[11][11], 3'b010);
        chk("t1_pix_20_15_grid", scr[20][15], 3'b000);

        // Empty then white at the same cell, back to back
        first_cyc = -1;
        base = n_plot;
        strobe(8'd22, 7'd9, 2'd0, 1'b1);
        strobe(8'd22, 7'd9, 2'd2, 1'b1);
        wait_idle(600);
        chk("t2_plot_count", n_plot - base, 2 * C * C);
        chk("t2_span_one_gap", last_cyc - first_cyc + 1, 2 * C * C + 1);
        chk("t2_white_27_14", scr[27][14], 3'b111);

        // Overflow: six consecutive strobes, the sixth is lost
        chk("ovf_before", overflow, 0);
        for (int n = 0; n < 5; n++) strobe_rand(1'b1);
        chk("ovf_after_5", overflow, 0);
        strobe_rand(1'b0);
        chk("ovf_after_6", overflow, 1);
        wait_idle(1200);
        chk("ovf_sticky", overflow, 1);
        do_reset();
        chk("ovf_cleared_by_reset", overflow, 0);

        // Screen wrap
        strobe(8'd250, 7'd125, 2'($urandom_range(0, 3)), 1'b1);
        wait_idle(400);
        chk("wrap_grid_5_8", scr[5][8], 3'b000);

        // Push and pop on the same edge while full
        for (int n = 0; n < 5; n++) strobe_rand(1'b1);
        chk("full_no_ovf", overflow, 0);
        k = 0;
        while (dbg_state !== LOAD && k < 400) begin
            tick(1);
            k++;
        end
        chk("load_timeout", 32'(k >= 400), 0);
        strobe_rand(1'b1);
        chk("full_pushpop_no_ovf", overflow, 0);
        wait_idle(1500);
        chk("full_pushpop_ovf_end", overflow, 0);

        // Random bursts that never exceed the FIFO depth
        for (int b = 0; b < 6; b++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int r = 0; r < n; r++) begin
                strobe_rand(1'b1);
                tick($urandom_range(0, 3));
            end
            wait_idle(1000);
        end
        chk("rand_no_ovf", overflow, 0);

        // Reset in the middle of a tile with two requests queued
        for (int n = 0; n < 3; n++) strobe_rand(1'b1);
        base = n_plot;
        k = 0;
        while (n_plot < base + 50 && k < 300) begin
            tick(1);
            k++;
        end
        chk("mid_draw_timeout", 32'(k >= 300), 0);
        skip_run = 1'b1;
        resetn = 1'b1;
        tick(1);
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        tick(2);
        resetn = 1'b0;
        tick(200);
        skip_run = 1'b0;
        chk("abort_idle_plot", plot, 0);
        chk("abort_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cell_plotter.md
Name: cell_plotter

Overview:
- Consumer end of the board cell plot stream: x_plot, y_plot, select, enable.
- Each accepted request is one board cell. The block renders it as a CELL_SIZE x CELL_SIZE pixel tile for the VGA adapter, one pixel per clock.
- A small FIFO absorbs cell requests, because the producer has no backpressure.
- Sits between the board RAM plot port and the vga_adapter x/y/colour/plot inputs.

Parameters:
- FIFO_DEPTH, 4, number of buffered cell requests (power of two, >=2).
- CELL_SIZE, 12, tile edge in pixels; the last row/column is grid line.
- BG_COLOUR, 3'b010, empty-square colour (green).

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-high reset.
- x_plot  in  8  tile top-left x pixel.
- y_plot  in  7  tile top-left y pixel.
- select  in  2  cell state: 0/1 empty, 2 white disk, 3 black disk.
- enable  in  1  request strobe; every clock it is high is one request.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high when FIFO non-empty or FSM not IDLE.
- overflow  out  1  sticky; a request was dropped.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clock, resetn).
- Reset:
  - FIFO emptied; FSM=IDLE.
  - vga_x=0, vga_y=0, colour=0, plot=0, busy=0, overflow=0.
  - Reset mid-draw aborts the tile: plot=0 from the cycle after the reset edge, and queued requests are lost.
- FIFO:
  - Entry = {x_plot, y_plot, select}, 17 bits.
  - Push on any edge where enable=1 and (not full, or a pop occurs on the same edge).
  - Push while full with no pop: request dropped, overflow<=1 until reset.
  - Pop only by FSM in LOAD. Empty FIFO never pops.
- FSM states:
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD: pop the head into base_x/base_y/sel regs; i=0, j=0; go to DRAW.
  - DRAW: each cycle output pixel (i,j) registered and plot=1. Increment i; on i=CELL_SIZE-1 wrap i=0 and increment j.
  - After pixel (CELL_SIZE-1, CELL_SIZE-1): go to LOAD if FIFO non-empty (as seen that cycle, including a same-cycle push), else IDLE.
- Latency:
  - enable high at edge k (FIFO empty, IDLE) -> IDLE->LOAD at k+1 -> LOAD->DRAW at k+2.
  - First plot=1 in the cycle after edge k+3.
  - Exactly CELL_SIZE^2 (144) consecutive plot cycles per tile.
  - Back-to-back tiles have one LOAD cycle with plot=0 between them.
- Pixel address:
  - vga_x = base_x + i, mod 256.
  - vga_y = base_y + j, mod 128.
  - Wrap is silent, no clipping.
- Colour per pixel, with C=CELL_SIZE:
  - i=C-1 or j=C-1: 3'b000 (grid line).
  - Else if sel>=2 and 2<=i,j<=C-3 and not both i and j in {2, C-3}: 3'b111 if sel=2, 3'b000 if sel=3. This is the disk with clipped corners.
  - Else: BG_COLOUR.
- plot is 0 in IDLE and LOAD. vga_x/vga_y/colour hold their last values when plot=0.
- busy is combinational from FIFO count and state.

Decomposition:
- othello_pkg:
  - select encodings: SEL_EMPTY0=0, SEL_EMPTY1=1, SEL_WHITE=2, SEL_BLACK=3.
  - colour constants: COL_GRID, COL_WHITE, COL_BLACK, COL_BOARD.
  - FSM state encoding: IDLE, LOAD, DRAW.
- Sub-module plot_fifo: synchronous FIFO, parameters WIDTH and DEPTH; outputs full, empty, dout. Same-edge push/pop is legal when full.

Test Plan:
- Single tile: enable one cycle with x=9, y=9, select=3.
  -> plot goes high 3 cycles later for 144 cycles.
  -> First pixel (9,9) is BG_COLOUR; pixel (14,14) is 3'b000; pixel (11,11) is BG_COLOUR (clipped corner); pixel (20,15) is grid 3'b000.
  -> busy falls the cycle after the last pixel.
- Empty vs white: two strobes, select=0 then select=2 at x=22.
  -> First tile has no 3'b111 pixels; second has 3'b111 at (27,14).
  -> Exactly one plot=0 gap between tiles; total 288 plot cycles.
- Overflow: 6 strobes on consecutive cycles with FIFO_DEPTH=4.
  -> The 6th request is dropped; overflow=1 sticky; exactly 5 tiles drawn (one popped early frees a slot).
- Wrap: x=250, y=125.
  -> vga_x sequence 250..255,0..5 and vga_y 125..127,0..8; no X values on any output.
- Reset mid-draw: assert resetn at pixel 50 with 2 entries queued.
  -> plot=0 and busy=0 the next cycle; no further plots after reset is released.
- Simultaneous push/pop when full: fill FIFO, then strobe in the LOAD cycle.
  -> Request accepted; overflow stays 0; one extra tile drawn.
